// File: rtl/rr_channel_arbiter_pkg.sv
// rtl/rr_channel_arbiter_pkg.sv - shared constants for the channel arbiter and mux/decoder wrappers
package rr_channel_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/rr_channel_arbiter_rr_pick.sv
// rtl/rr_channel_arbiter_rr_pick.sv - combinational round-robin winner search starting at ptr
module rr_pick
    import rr_channel_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               valid,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit is assigned last and wins.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_channel_arbiter.sv
// rtl/rr_channel_arbiter.sv - round-robin arbiter driving the shared 4:1 channel select
module rr_channel_arbiter
    import rr_channel_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy,
    output logic [HOLD_W-1:0]  hold_cnt
);

    logic [0:0]         state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    logic               release_w;
    logic [SEL_W-1:0]   next_ptr;
    logic [SEL_W-1:0]   pick_ptr;
    logic               pick_valid;
    logic [SEL_W-1:0]   pick_idx;

    assign next_ptr  = sel_q + SEL_W'(1);
    assign release_w = (state_q == ST_GRANT) &&
                       (!req[sel_q] || (hold_q == HOLD_W'(MAX_HOLD - 1)));
    // On release the search restarts just past the holder, so one picker serves both paths.
    assign pick_ptr  = (state_q == ST_GRANT) ? next_ptr : ptr_q;

    rr_pick u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        if (state_q == ST_GRANT && !release_w) begin
            hold_d = hold_q + HOLD_W'(1);
        end else begin
            if (state_q == ST_GRANT) begin
                ptr_d = next_ptr;
            end
            if (pick_valid) begin
                state_d = ST_GRANT;
                sel_d   = pick_idx;
                gnt_d   = NUM_REQ'(1) << pick_idx;
                busy_d  = 1'b1;
                hold_d  = '0;
            end else begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

    assign sel      = sel_q;
    assign gnt      = gnt_q;
    assign busy     = busy_q;
    assign hold_cnt = hold_q;

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// tb/tb_rr_channel_arbiter.sv - randomized and directed checks of rr_channel_arbiter against a behavioural model
module tb_rr_channel_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int HOLD_W   = 8;

    logic              clk;
    logic              rst_n;
    logic [3:0]        req;
    logic [1:0]        sel;
    logic [3:0]        gnt;
    logic              busy;
    logic [HOLD_W-1:0] hold_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who owns the channel (-1 = nobody), how long, where the next search starts.
    int m_owner, m_ptr, m_sel, m_cnt;

    rr_channel_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .sel      (sel),
        .gnt      (gnt),
        .busy     (busy),
        .hold_cnt (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_sel   = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int w;
        if (m_owner >= 0 && r[m_owner] && m_cnt < MAX_HOLD - 1) begin
            m_cnt++;
        end else begin
            if (m_owner >= 0) m_ptr = (m_owner + 1) % 4;
            w = pick(r, m_ptr);
            m_owner = w;
            m_cnt   = 0;
            if (w >= 0) m_sel = w;
        end
    endtask

    task automatic compare_model();
        int unsigned exp_gnt;
        exp_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        chk("sel", sel, m_sel);
        chk("gnt", gnt, exp_gnt);
        chk("busy", busy, (m_owner >= 0) ? 1 : 0);
        if (m_owner >= 0) chk("hold_cnt", hold_cnt, m_cnt);
        chk("inv_onehot", ($countones(gnt) <= 1) ? 1 : 0, 1);
        chk("inv_busy", busy, |gnt);
        if (busy) chk("inv_sel", gnt, 4'b0001 << sel);
    endtask

    // Drive req for one sampling edge, advance the model, check on the following falling edge.
    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_model();
        rst_n = 1'b1;
    endtask

    // Reset asserted between edges must clear outputs without any clock edge.
    task automatic async_reset_pulse(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_hold"}, hold_cnt, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        rst_n = 1'b0;
        req   = 4'h0;
        model_reset();
        @(negedge clk);

        // Idle after reset
        do_reset();
        repeat (5) step(4'h0);
        chk("idle_gnt", gnt, 0);
        chk("idle_busy", busy, 0);
        chk("idle_sel", sel, 0);
        chk("idle_hold", hold_cnt, 0);

        // Single request held for 3 cycles then dropped
        do_reset();
        step(4'b0100);
        chk("single_gnt", gnt, 4'h4);
        chk("single_sel", sel, 2);
        chk("single_h0", hold_cnt, 0);
        step(4'b0100);
        chk("single_h1", hold_cnt, 1);
        step(4'b0100);
        chk("single_h2", hold_cnt, 2);
        step(4'b0000);
        chk("drop_gnt", gnt, 0);
        chk("drop_busy", busy, 0);

        // All requesting: 8-cycle slices rotating 0,1,2,3,0 without gaps
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            step(4'hF);
            chk("rot_gnt", gnt, 4'b0001 << (((k - 1) / 8) % 4));
        end

        // Lone holder re-granted to itself on timeout
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(4'b0010);
            chk("self_gnt", gnt, 4'h2);
            chk("self_hold", hold_cnt, (k - 1) % 8);
        end

        // Holder 3 drops while 0 and 1 request: ptr wraps to 0, no bubble
        do_reset();
        step(4'b1000);
        chk("h3_gnt", gnt, 4'h8);
        step(4'b1000);
        step(4'b0011);
        chk("h3_next_gnt", gnt, 4'h1);
        chk("h3_next_sel", sel, 0);
        repeat (8) step(4'b0011);
        chk("h3_then1_gnt", gnt, 4'h2);
        chk("h3_then1_sel", sel, 1);

        // Reset mid-grant, next arbitration starts from ptr=0
        do_reset();
        repeat (5) step(4'b0100);
        chk("mid_hold", hold_cnt, 4);
        async_reset_pulse("mid_rst");
        step(4'b0110);
        chk("post_rst_gnt", gnt, 4'h2);
        chk("post_rst_sel", sel, 1);

        // Randomized traffic with sticky request patterns and occasional async resets
        do_reset();
        r = 4'h0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) async_reset_pulse("rnd_rst");
            step(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
